// File: rtl/seq_scan_pkg.sv
// Shared encodings and constants for the serial "1001" scan path.
// Pure declarations; no logic, no latency.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [3:0] DEF_PATTERN = 4'b1001;
  localparam int         PAT_LEN     = 4;

endpackage

// File: rtl/seq_window_det.sv
// Sliding pattern window with combinational Mealy match on the incoming bit.
// Match is same-cycle; window advances only when i_shift_en is high.
module seq_window_det
  import seq_scan_pkg::*;
#(
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_shift_en,
  input  logic i_bit,
  output logic o_match,
  output logic o_qual
);

  localparam logic [1:0] FILL_MAX = 2'(PAT_LEN - 1);

  // Only the last PAT_LEN-1 bits are stored; the incoming bit completes the window.
  logic [PAT_LEN-2:0] r_win;
  logic [1:0]         r_fill;
  logic [PAT_LEN-1:0] w_win_nxt;

  assign w_win_nxt = {r_win, i_bit};
  assign o_qual    = (r_fill == FILL_MAX);
  assign o_match   = o_qual && (w_win_nxt == PATTERN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (i_shift_en) begin
      r_win <= w_win_nxt[PAT_LEN-2:0];
      if (r_fill != FILL_MAX) r_fill <= r_fill + 2'd1;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serialises a word into the pattern window, counting overlapping matches.
// Result valid WIDTH+1 edges after accept; held in DONE until out_ready or abort.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int              WIDTH   = 16,
  parameter int              CNT_W   = 5,
  parameter logic [3:0]      PATTERN = DEF_PATTERN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] first_pos,
  output logic             found,
  output logic             busy
);

  localparam logic [CNT_W-1:0] IDX_END = CNT_W'(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic             r_msb;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pos;
  logic             r_found;

  logic w_accept, w_shift_en, w_clr_res;
  logic w_bit, w_match, w_qual;

  assign w_bit = r_msb ? r_shift[WIDTH-1] : r_shift[0];

  seq_window_det #(.PATTERN(PATTERN)) u_det (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_accept),
    .i_shift_en (w_shift_en),
    .i_bit      (w_bit),
    .o_match    (w_match),
    .o_qual     (w_qual)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // SHIFT spends one extra cycle at r_idx == WIDTH before entering DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift_en  = 1'b0;
    w_clr_res   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_clr_res   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_idx == IDX_END) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_shift_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (abort) begin
          w_clr_res   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_msb   <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_found <= 1'b0;
    end else if (w_accept) begin
      r_shift <= in_data;
      r_msb   <= msb_first;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_found <= 1'b0;
    end else if (w_clr_res) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_found <= 1'b0;
    end else if (w_shift_en) begin
      r_shift <= r_msb ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
      r_idx   <= r_idx + 1'b1;
      if (w_match && w_qual) begin
        r_cnt <= r_cnt + 1'b1;
        if (!r_found) begin
          r_pos   <= r_idx;
          r_found <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_SHIFT);
  assign match_cnt = r_cnt;
  assign first_pos = r_pos;
  assign found     = r_found;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Table-driven and hand-sequenced checks of seq_scan_ctrl with a result scoreboard.
module tb_seq_scan_ctrl;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk, reset;
  logic          in_valid, in_ready, msb_first, abort;
  logic          out_valid, out_ready, found, busy;
  logic [W-1:0]  in_data;
  logic [CW-1:0] match_cnt, first_pos;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic          msb;
    logic [CW-1:0] cnt;
    logic [CW-1:0] pos;
    logic          fnd;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[9];

  seq_scan_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .msb_first (msb_first),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .match_cnt (match_cnt),
    .first_pos (first_pos),
    .found     (found),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string nm);
    chk({nm, "_in_ready"},  in_ready,  1);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_busy"},      busy,      0);
    chk({nm, "_match_cnt"}, match_cnt, 0);
    chk({nm, "_first_pos"}, first_pos, 0);
    chk({nm, "_found"},     found,     0);
  endtask

  task automatic accept(input logic [W-1:0] d, input logic m);
    chk("in_ready_before_accept", in_ready, 1);
    in_data   = d;
    msb_first = m;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) fail("timeout_waiting_out_valid");
  endtask

  task automatic score();
    vec_t e;
    if (sb.size() == 0) begin
      fail("scoreboard_underflow");
      return;
    end
    e = sb.pop_front();
    chk("out_valid",  out_valid, 1);
    chk("match_cnt",  match_cnt, e.cnt);
    chk("first_pos",  first_pos, e.pos);
    chk("found",      found,     e.fnd);
    chk("in_ready_done", in_ready, 0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_after_ready", out_valid, 0);
    chk("in_ready_after_ready",  in_ready,  1);
  endtask

  task automatic run(input vec_t v);
    int n;
    sb.push_back(v);
    accept(v.data, v.msb);
    wait_out(n);
    chk("latency", n, W + 1);
    score();
    release_out();
  endtask

  initial begin
    int   n;
    logic seen;
    vec_t v;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    msb_first = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;

    #2;
    chk_idle_reset("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_idle_reset("post_reset");

    vecs[0] = '{16'h0049, 1'b0, 5'd2, 5'd3,  1'b1};
    vecs[1] = '{16'h9000, 1'b1, 5'd1, 5'd3,  1'b1};
    vecs[2] = '{16'h9000, 1'b0, 5'd1, 5'd15, 1'b1};
    vecs[3] = '{16'h0000, 1'b0, 5'd0, 5'd0,  1'b0};
    vecs[4] = '{16'hFFFF, 1'b1, 5'd0, 5'd0,  1'b0};
    vecs[5] = '{16'h9249, 1'b0, 5'd5, 5'd3,  1'b1};
    vecs[6] = '{16'h0049, 1'b1, 5'd2, 5'd12, 1'b1};
    vecs[7] = '{16'h4924, 1'b1, 5'd4, 5'd4,  1'b1};
    vecs[8] = '{16'h0009, 1'b0, 5'd1, 5'd3,  1'b1};
    for (int i = 0; i < 9; i++) run(vecs[i]);

    // Back-pressure in DONE with a competing in_valid.
    sb.push_back(vecs[0]);
    accept(16'h0049, 1'b0);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_match_cnt", match_cnt, 2);
      chk("bp_first_pos", first_pos, 3);
      chk("bp_in_ready",  in_ready,  0);
    end
    in_valid = 1'b0;
    score();
    release_out();

    // Abort at shift index 8.
    accept(16'h0049, 1'b0);
    repeat (8) tick();
    chk("pre_abort_busy", busy, 1);
    chk("pre_abort_cnt",  match_cnt, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle_reset("abort_shift");
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("no_out_after_abort", seen, 0);
    run(vecs[5]);

    // Abort in IDLE does not block a simultaneous accept.
    sb.push_back(vecs[8]);
    in_data   = 16'h0009;
    msb_first = 1'b0;
    in_valid  = 1'b1;
    abort     = 1'b1;
    tick();
    in_valid  = 1'b0;
    abort     = 1'b0;
    chk("idle_abort_busy", busy, 1);
    wait_out(n);
    chk("idle_abort_latency", n, W + 1);
    score();
    release_out();

    // Abort while holding a result in DONE.
    sb.push_back(vecs[7]);
    accept(16'h4924, 1'b1);
    wait_out(n);
    score();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle_reset("abort_done");

    // Asynchronous reset mid-SHIFT.
    accept(16'h9249, 1'b0);
    repeat (5) tick();
    chk("pre_reset_cnt", match_cnt, 1);
    #2 reset = 1'b0;
    #1;
    chk_idle_reset("async_reset");
    #1 reset = 1'b1;
    tick();
    v = vecs[8];
    run(v);

    if (sb.size() != 0) fail("scoreboard_leftover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
